simon_btn_debounce: RTL

- Input conditioning stage directly upstream of the simon game core. Replaces the direct wiring of ui_in[3:0] to simon's btn.
- Synchronises four raw push-button pins and debounces them on a millisecond timebase derived from the same ticks_per_milli value the core uses (62 for the internal ring oscillator, 50 for the external clock).
- Delivers clean levels plus one-cycle press/release pulses to the core.

---
 rtl/simon_pkg.sv | 20 ++
 rtl/simon_btn_chan.sv | 98 +++++++++
 rtl/simon_btn_debounce.sv | 69 ++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared constants for the simon button front end: channel count, counter
// widths, button indices and the prescaler period helper.
package simon_pkg;

   localparam int NUM_BTNS  = 4;
   localparam int MS_CNT_W  = 16;
   localparam int DB_CNT_W  = 8;
   localparam int RPT_CNT_W = 10;

   localparam int BTN_RED    = 0;
   localparam int BTN_GREEN  = 1;
   localparam int BTN_BLUE   = 2;
   localparam int BTN_YELLOW = 3;

   // A zero period would stall the prescaler, so it is treated as one cycle.
   function automatic logic [MS_CNT_W-1:0] tpm_eff(input logic [MS_CNT_W-1:0] tpm);
      return (tpm == '0) ? MS_CNT_W'(1) : tpm;
   endfunction

endpackage

// File: rtl/simon_btn_chan.sv
// One button channel: 2-flop synchroniser, ms-based debounce, press/release pulses.
// Auto-repeat while held is built only when SIMON_BTN_REPEAT_EN is defined.
module simon_btn_chan
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_MS = 5
`ifdef SIMON_BTN_REPEAT_EN
   ,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 150
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic i_ms_tick,
   input  logic i_btn_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_MS - 1);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_level;
   logic                r_press;
   logic                r_release;
   logic [DB_CNT_W-1:0] r_cnt;
   logic                w_diff;
   logic                w_toggle;

   always_comb begin
      w_diff   = (r_sync2 != r_level);
      w_toggle = w_diff && i_ms_tick && (r_cnt == DB_LAST);
   end

   // Any cycle where the input agrees with the level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_release <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn_raw;
         r_sync2   <= r_sync1;
         r_release <= w_toggle && r_level;
         if (w_toggle)
            r_level <= ~r_level;
         if (!w_diff || w_toggle)
            r_cnt <= '0;
         else if (i_ms_tick)
            r_cnt <= r_cnt + DB_CNT_W'(1);
      end
   end

`ifdef SIMON_BTN_REPEAT_EN
   localparam logic [RPT_CNT_W-1:0] RPT_LAST   = RPT_CNT_W'(REPEAT_DELAY_MS - 1);
   localparam logic [RPT_CNT_W-1:0] RPT_RELOAD = RPT_CNT_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);

   logic [RPT_CNT_W-1:0] r_hold;
   logic                 w_repeat;

   // A falling debounce wins over a repeat landing on the same tick.
   always_comb begin
      w_repeat = r_level && !w_toggle && i_ms_tick && (r_hold == RPT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_press <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_press <= (w_toggle && !r_level) || w_repeat;
         if (!r_level || w_toggle)
            r_hold <= '0;
         else if (w_repeat)
            r_hold <= RPT_RELOAD;
         else if (i_ms_tick)
            r_hold <= r_hold + RPT_CNT_W'(1);
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst)
         r_press <= 1'b0;
      else
         r_press <= w_toggle && !r_level;
   end
`endif

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/simon_btn_debounce.sv
// Button conditioning ahead of the simon core: shared ms prescaler plus one
// debounce channel per button. Optional auto-repeat: SIMON_BTN_REPEAT_EN.
module simon_btn_debounce
   import simon_pkg::*;
#(
   parameter int NUM_BTNS        = simon_pkg::NUM_BTNS,
   parameter int DEBOUNCE_MS     = 5,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 150
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [MS_CNT_W-1:0] ticks_per_milli,
   input  logic [NUM_BTNS-1:0] btn_raw,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic                btn_any
);

   if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_debounce
      $error("DEBOUNCE_MS must be within 1..255");
   end
   if (REPEAT_RATE_MS < 1 || REPEAT_RATE_MS > REPEAT_DELAY_MS ||
       REPEAT_DELAY_MS > 1023) begin : g_bad_repeat
      $error("repeat timing must satisfy 1 <= rate <= delay <= 1023");
   end

   logic [MS_CNT_W-1:0] r_ms_cnt;
   logic [MS_CNT_W-1:0] w_tpm_eff;
   logic                w_ms_tick;

   // ">=" rather than "==" so a period shrinking below the count ticks at once.
   always_comb begin
      w_tpm_eff = tpm_eff(ticks_per_milli);
      w_ms_tick = (r_ms_cnt >= (w_tpm_eff - MS_CNT_W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ms_cnt <= '0;
      else if (w_ms_tick)
         r_ms_cnt <= '0;
      else
         r_ms_cnt <= r_ms_cnt + MS_CNT_W'(1);
   end

   for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      simon_btn_chan #(
         .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef SIMON_BTN_REPEAT_EN
         ,
         .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
         .REPEAT_RATE_MS  (REPEAT_RATE_MS)
`endif
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_ms_tick (w_ms_tick),
         .i_btn_raw (btn_raw[gi]),
         .o_level   (btn_level[gi]),
         .o_press   (btn_press[gi]),
         .o_release (btn_release[gi])
      );
   end

   assign btn_any = |btn_level;

endmodule
